// File: rtl/tcdm_pkg.sv
// Shared helpers for the TCDM response-buffer slice.
package tcdm_pkg;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_intf.sv
// Request/response memory port used between the upcast stage, buffers and TCDM banks.
interface mem_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output req, addr, wen, data, be, r_ready,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, addr, wen, data, be, r_ready,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/tcdm_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is registered storage, never the
// incoming word (no fall-through). Full/empty come from the count, not pointers.
module tcdm_sync_fifo
    import tcdm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int CW        = cnt_width(DEPTH),
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    // Pop is gated by empty, so a push into an empty FIFO is simply stored.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_rsp_buffer.sv
// Credit-limited response buffer in front of a TCDM bank that cannot be back-pressured.
// Reads are admitted only while in-flight reads plus buffered responses leave a free slot.
module tcdm_rsp_buffer
    import tcdm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    mem_intf.slave  slv,
    mem_intf.master mst,
    output logic    err_o
);

    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  credit_ok;
    logic                  read_accept;
    logic                  has_outstanding;
    logic                  rsp_push;
    logic                  rsp_err;
    logic                  rsp_pop;

    // One extra bit so the sum cannot wrap for any DEPTH.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);

    assign mst.req   = slv.req & (slv.wen | credit_ok);
    assign slv.gnt   = mst.gnt & (slv.wen | credit_ok);
    assign mst.addr  = slv.addr;
    assign mst.wen   = slv.wen;
    assign mst.data  = slv.data;
    assign mst.be    = slv.be;
    assign mst.r_ready = 1'b1;

    assign read_accept     = slv.req & slv.gnt & ~slv.wen;
    assign has_outstanding = (outstanding_q != '0);
    assign rsp_push        = mst.r_valid & has_outstanding & ~fifo_full;
    assign rsp_err         = mst.r_valid & (~has_outstanding | fifo_full);

    assign rsp_pop     = slv.r_ready & ~fifo_empty;
    assign slv.r_valid = ~fifo_empty;
    assign slv.r_data  = fifo_head;

    tcdm_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (rsp_push),
        .data_in (mst.r_data),
        .pop     (rsp_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A response to a real in-flight read retires it even if it had to be dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({read_accept, mst.r_valid & has_outstanding})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (rsp_err) begin
            err_o <= 1'b1;
        end
    end

    credit_bound_a : assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, outstanding_q} + {1'b0, fifo_count}) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_tcdm_rsp_buffer.sv
// Randomised and directed bench for tcdm_rsp_buffer against a queue-based reference model.
module tb_tcdm_rsp_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic err_o;

    always #5 clk_i = ~clk_i;

    mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) slv_if ();
    mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mst_if ();

    tcdm_rsp_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .slv   (slv_if),
        .mst   (mst_if),
        .err_o (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: in-flight reads, buffered responses, sticky error, bank pipeline.
    int            m_out;
    logic [DW-1:0] m_fifo[$];
    logic          m_err;
    logic [DW-1:0] bank_q[$];
    logic [DW-1:0] bank_next;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle();
        slv_if.req     = 1'b0;
        slv_if.wen     = 1'b0;
        slv_if.addr    = '0;
        slv_if.data    = '0;
        slv_if.be      = '0;
        slv_if.r_ready = 1'b0;
        mst_if.gnt     = 1'b0;
        mst_if.r_valid = 1'b0;
        mst_if.r_data  = '0;
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic run_cycle(input logic req, input logic wen, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [DW/8-1:0] be,
                             input logic gnt, input logic rdy, input logic bank_en,
                             input logic force_rv);
        logic          credit, exp_gnt, bank_v, accept, pop, push_ok;
        logic [DW-1:0] bank_d;
        bank_v = force_rv | (bank_en && bank_q.size() > 0);
        bank_d = (bank_q.size() > 0) ? bank_q[0] : 32'h0BAD_0BAD;
        slv_if.req     = req;
        slv_if.wen     = wen;
        slv_if.addr    = addr;
        slv_if.data    = data;
        slv_if.be      = be;
        slv_if.r_ready = rdy;
        mst_if.gnt     = gnt;
        mst_if.r_valid = bank_v;
        mst_if.r_data  = bank_d;
        #1;
        credit  = (m_out + m_fifo.size()) < DEPTH;
        exp_gnt = gnt & (wen | credit);
        check_val("slv_gnt", slv_if.gnt, exp_gnt);
        check_val("mst_req", mst_if.req, req & (wen | credit));
        check_val("mst_r_ready", mst_if.r_ready, 1'b1);
        if (req) begin
            check_val("mst_addr", mst_if.addr, addr);
            check_val("mst_wen", mst_if.wen, wen);
            check_val("mst_data", mst_if.data, data);
            check_val("mst_be", mst_if.be, be);
        end
        check_val("slv_r_valid", slv_if.r_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) begin
            check_val("slv_r_data", slv_if.r_data, m_fifo[0]);
        end
        check_val("err_o", err_o, m_err);

        accept  = req & exp_gnt & ~wen;
        pop     = (m_fifo.size() > 0) & rdy;
        push_ok = bank_v && (m_out > 0) && (m_fifo.size() < DEPTH);
        if (bank_v && !push_ok) m_err = 1'b1;
        if (pop) void'(m_fifo.pop_front());
        if (push_ok) m_fifo.push_back(bank_d);
        if (bank_v && m_out > 0) m_out--;
        if (accept) m_out++;
        if (bank_v && bank_q.size() > 0) void'(bank_q.pop_front());
        if (accept) begin
            bank_q.push_back(bank_next);
            bank_next = bank_next + 1;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_cycle(input logic rdy, input logic bank_en);
        run_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, rdy, bank_en, 1'b0);
    endtask

    // Async reset: outputs must clear before any clock edge; grant follows inputs with full credit.
    task automatic apply_reset();
        drive_idle();
        slv_if.req = 1'b1;
        mst_if.gnt = 1'b1;
        rst_i = 1'b1;
        #1;
        check_val("rst_r_valid", slv_if.r_valid, 1'b0);
        check_val("rst_err", err_o, 1'b0);
        check_val("rst_gnt", slv_if.gnt, 1'b1);
        check_val("rst_mst_req", mst_if.req, 1'b1);
        m_out = 0;
        m_fifo.delete();
        m_err = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        m_out     = 0;
        m_err     = 1'b0;
        bank_next = '0;
        drive_idle();
        @(negedge clk_i);

        // Single read at 0x40 answered one cycle later.
        apply_reset();
        bank_q.delete();
        bank_next = 32'hDEAD_BEEF;
        run_cycle(1'b1, 1'b0, 32'h40, '0, '1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b1, 1'b0);

        // Six back-to-back reads with r_ready low: only DEPTH are admitted.
        apply_reset();
        bank_q.delete();
        bank_next = 32'h1;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 1'b0, 32'h100 + 32'(4 * i), '0, '1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        idle_cycle(1'b0, 1'b1);
        // Write while credits are exhausted.
        run_cycle(1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0);
        // Reads and pops together from a full buffer; order must hold.
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0, 32'h300 + 32'(4 * i), '0, '1, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) idle_cycle(1'b1, 1'b1);

        // Spurious bank response sets a sticky error.
        apply_reset();
        bank_q.delete();
        run_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle_cycle(1'b1, 1'b0);

        // Reset with two reads in flight, then late responses, then a clean read.
        apply_reset();
        bank_q.delete();
        bank_next = 32'hA0;
        run_cycle(1'b1, 1'b0, 32'h10, '0, '1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h14, '0, '1, 1'b1, 1'b1, 1'b0, 1'b0);
        apply_reset();
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b1, 1'b1);
        bank_next = 32'hB0;
        run_cycle(1'b1, 1'b0, 32'h18, '0, '1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b1, 1'b0);

        // Randomised traffic with a random-latency in-order bank.
        apply_reset();
        bank_q.delete();
        for (int i = 0; i < 1500; i++) begin
            bank_next = $urandom;
            run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom, $urandom,
                      4'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 1) == 1, 1'b0);
        end
        for (int i = 0; i < 20; i++) idle_cycle(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tcdm_rsp_buffer.md
# tcdm_rsp_buffer

Wide-side response buffer placed between the upcast stage's wide master port and a TCDM bank that cannot accept response back-pressure. It forwards requests combinationally, limits outstanding reads to the free slots in an internal response FIFO using a credit counter, and absorbs bank responses into that FIFO. The upstream port then sees a proper r_valid/r_ready handshake. Writes pass straight through and produce no response.

## Interface
Parameters:
- DATA_WIDTH, 32: wide data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32: address width in bits.
- DEPTH, 4: response FIFO entries, which is also the maximum number of outstanding reads; must be at least 1.

Ports:
- clk_i  in  1  clock; all state is updated on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- slv  mem_intf.slave  DATA_WIDTH/ADDR_WIDTH  upstream port, driven by the upcast stage. Signals used: req, gnt, addr, wen, data, be, r_data, r_valid, r_ready.
- mst  mem_intf.master  DATA_WIDTH/ADDR_WIDTH  downstream port to the bank. The bank asserts r_valid for reads only and ignores r_ready.
- err_o  out  1  sticky error flag: set by a spurious or overflowing bank response, cleared only by reset.

## Operation
- Credit: credit_ok = (outstanding_q + fifo_count) < DEPTH.
  - outstanding_q counts reads granted by the bank whose r_valid has not yet arrived.
  - Width of both counters: $clog2(DEPTH+1).
- Request path:
  - mst.req = slv.req & (slv.wen | credit_ok); slv.gnt = mst.gnt & (slv.wen | credit_ok).
  - Writes are never blocked.
  - addr, wen, data and be pass through unchanged.
- Read accept is slv.req & slv.gnt & ~slv.wen. On accept, outstanding_q increments.
- Bank response: mst.r_valid pushes mst.r_data into the FIFO and decrements outstanding_q.
- If a read accept and a bank response occur in the same cycle, outstanding_q is unchanged.
- Upstream response: slv.r_valid = FIFO not empty; slv.r_data = FIFO head.
  - Pop on slv.r_valid & slv.r_ready.
  - slv.r_data is held stable while r_valid=1 and r_ready=0.
- mst.r_ready is tied to 1.
- Responses are returned strictly in bank-response order; there is no reordering.
- Error cases:
  - mst.r_valid with outstanding_q==0: response dropped, err_o set.
  - mst.r_valid with FIFO full: response dropped, err_o set. The credit rule makes this unreachable for a compliant bank.
- FIFO pointers wrap modulo DEPTH. Full and empty are derived from fifo_count, not from pointer equality.
- Push and pop in the same cycle:
  - FIFO not empty: both take effect and fifo_count is unchanged.
  - FIFO empty: the push is stored and no pop occurs (no fall-through).

## Timing
- Request path has zero latency: mst.req, addr, data and be, and slv.gnt, are combinational.
- Response latency: slv.r_valid rises on the cycle after mst.r_valid. There is no combinational path from mst.r_valid to slv.r_valid.
- Throughput: full rate (one read per cycle) when DEPTH ≥ bank latency + 1 and r_ready is held high.
- Credit release on pop takes effect in the following cycle: credit_ok uses the registered counts.
- Reset values:
  - slv.r_valid=0, err_o=0, outstanding_q=0, fifo_count=0, pointers=0.
  - slv.gnt and mst.req follow their inputs, with credit_ok=1.
- Reset mid-operation: in-flight reads and buffered responses are discarded. A late bank r_valid after reset is handled as spurious (dropped, err_o=1).

## Structure
- Sub-module tcdm_sync_fifo: parametric DATA_WIDTH/DEPTH synchronous FIFO providing push, pop, count, full, empty and head data, with no fall-through.
- The credit counter and the request and error logic stay in tcdm_rsp_buffer.
- tcdm_pkg holds the shared function cnt_width(depth) = $clog2(depth+1).
- No new typedefs are needed. mem_intf is reused unchanged.

## Test plan
- Single read, addr 0x40, bank returns 0xDEADBEEF one cycle later, r_ready=1 -> slv.r_valid is high exactly one cycle after mst.r_valid with r_data=0xDEADBEEF; err_o stays 0.
- DEPTH=4, r_ready=0, 6 back-to-back reads -> first 4 are granted; slv.gnt=0 for reads 5 and 6 until a pop; the FIFO holds 4 entries in order.
- Write request while credits are exhausted -> write is granted the same cycle with data/be unchanged on mst; no response is generated.
- Read accept and pop in the same cycle while full: outstanding_q and fifo_count are stable; data order 0x1,0x2,0x3,0x4 is preserved.
- mst.r_valid forced with no outstanding read -> response dropped, err_o=1 and held until rst_i.
- rst_i asserted with 2 reads in flight -> slv.r_valid=0 immediately; a subsequent late bank response sets err_o; the next read completes normally.
